// File: rtl/n4fpga_pwm_pkg.sv
// Shared constants and types for the RGB PWM generator.
// Latency: n/a (package only).
// Backpressure: n/a.
package n4fpga_pwm_pkg;

    // Default period counter width: one PWM period is 2^PWM_CNT_W ticks.
    localparam int PWM_CNT_W = 8;

    // Duty values need one extra bit so that a full-period duty (2^CNT_W) is expressible.
    localparam int DUTY_W = PWM_CNT_W + 1;

    localparam int NUM_CH = 3;

    typedef enum logic [1:0] {
        RED   = 2'd0,
        GREEN = 2'd1,
        BLUE  = 2'd2
    } colour_e;

endpackage

// File: rtl/n4fpga_pwm_channel.sv
// One PWM colour channel: pending/active duty, saturating clamp, compare, output register.
// Latency: pwm_o reflects the cnt_i and active duty of the previous tick.
// Backpressure: none; a load is always accepted and overwrites any pending value.
module n4fpga_pwm_channel
    import n4fpga_pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [CNT_W-1:0] cnt_i,
    input  logic             tick_i,
    input  logic             load_i,
    input  logic             apply_i,
    input  logic [CNT_W:0]   duty_i,
    output logic             pwm_o
);

    // A full period's worth of ticks; any larger duty saturates to this.
    localparam logic [CNT_W:0] FULL = {1'b1, {CNT_W{1'b0}}};

    logic [CNT_W:0] pend_q, pend_d;
    logic [CNT_W:0] act_q, act_d;
    logic [CNT_W:0] eff;
    logic           pwm_q, pwm_d;

    // Next-state: capture loads, promote pending at the boundary, compare on ticks.
    // When load and apply coincide, the old pending value is promoted and the new
    // one waits for the following boundary.
    always_comb begin
        pend_d = load_i  ? duty_i : pend_q;
        act_d  = apply_i ? pend_q : act_q;
        eff    = (act_q > FULL) ? FULL : act_q;
        pwm_d  = tick_i ? ({1'b0, cnt_i} < eff) : pwm_q;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
            act_q  <= '0;
            pwm_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            act_q  <= act_d;
            pwm_q  <= pwm_d;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/n4fpga_rgb_pwm_gen.sv
// Three-channel RGB PWM generator with double-buffered duties applied at period boundaries.
// Latency: outputs lag the counter by one tick; a load is visible within one period + 1 tick.
// Backpressure: none; optional tick prescaler enabled by defining PWM_PRESCALE_EN.
module n4fpga_rgb_pwm_gen
    import n4fpga_pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W
) (
    input  logic           clock_3,
    input  logic           Reset,
    input  logic [CNT_W:0] duty_red,
    input  logic [CNT_W:0] duty_green,
    input  logic [CNT_W:0] duty_blue,
`ifdef PWM_PRESCALE_EN
    input  logic [15:0]    prescale,
`endif
    input  logic           duty_load,
    output logic           pwm_red,
    output logic           pwm_green,
    output logic           pwm_blue,
    output logic           period_start,
    output logic           update_pending
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pend_q, pend_d;
    logic             ps_q, ps_d;
    logic             tick;
    logic             wrap;
    logic             apply;

    logic [CNT_W:0]    duty_in [NUM_CH];
    logic [NUM_CH-1:0] pwm;

`ifdef PWM_PRESCALE_EN
    logic [15:0] pre_cnt_q, pre_cnt_d;

    // Issue a tick once the divider reaches the live prescale value; >= lets a lowered value act at once.
    always_comb begin
        tick      = (pre_cnt_q >= prescale);
        pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
    end

    // Prescaler counter register.
    always_ff @(posedge clock_3) begin
        if (Reset) begin
            pre_cnt_q <= '0;
        end else begin
            pre_cnt_q <= pre_cnt_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // Period counter, boundary detection, pending flag and period-start pulse.
    // A load on the wrap tick keeps the flag set so its values wait one more period.
    always_comb begin
        cnt_d  = tick ? cnt_q + 1'b1 : cnt_q;
        wrap   = tick && (cnt_q == CNT_MAX);
        apply  = wrap && pend_q;
        pend_d = pend_q;
        if (duty_load) begin
            pend_d = 1'b1;
        end else if (apply) begin
            pend_d = 1'b0;
        end
        ps_d   = tick && (cnt_q == '0);
    end

    // Shared control registers.
    always_ff @(posedge clock_3) begin
        if (Reset) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
            ps_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
            ps_q   <= ps_d;
        end
    end

    assign duty_in[RED]   = duty_red;
    assign duty_in[GREEN] = duty_green;
    assign duty_in[BLUE]  = duty_blue;

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        n4fpga_pwm_channel #(
            .CNT_W (CNT_W)
        ) u_channel (
            .clk_i   (clock_3),
            .rst_i   (Reset),
            .cnt_i   (cnt_q),
            .tick_i  (tick),
            .load_i  (duty_load),
            .apply_i (apply),
            .duty_i  (duty_in[ch]),
            .pwm_o   (pwm[ch])
        );
    end

    assign pwm_red        = pwm[RED];
    assign pwm_green      = pwm[GREEN];
    assign pwm_blue       = pwm[BLUE];
    assign period_start   = ps_q;
    assign update_pending = pend_q;

endmodule
